// File: rtl/i2s_encoder_pkg.sv
// Shared constants, FSM encoding and slot-map helpers for the I2S transmitter.
// No logic; latency n/a.
// Backpressure n/a; imported by the interface, the sample buffer and the top.
package i2s_encoder_pkg;

    localparam int DATAWIDTH_DEF  = 24;
    localparam int SLOT_BITS_DEF  = 32;
    localparam int FRAME_BITS_DEF = 2 * SLOT_BITS_DEF;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // WS switches one slot ahead of each channel's MSB (Philips alignment).
    function automatic int ws_rise_slot(input int slot_bits);
        return slot_bits - 1;
    endfunction

    function automatic int ws_fall_slot(input int slot_bits);
        return 2 * slot_bits - 1;
    endfunction

    function automatic logic ws_for_slot(input int slot, input int slot_bits);
        return (slot >= ws_rise_slot(slot_bits) && slot < ws_fall_slot(slot_bits))
               ? WS_RIGHT : WS_LEFT;
    endfunction

endpackage

// File: rtl/i2s_encoder_if.sv
// Sample-side handshake bundle: one left/right PCM pair per valid/ready transfer.
// No logic; latency n/a.
// Backpressure: the slave holds ready_o low while it cannot take a pair.
// Signals: L_DATA_I/R_DATA_I (pair), valid_i (pair valid), ready_o (slave can accept).
interface i2s_encoder_if
    import i2s_encoder_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
);
    logic [DATAWIDTH-1:0] L_DATA_I;
    logic [DATAWIDTH-1:0] R_DATA_I;
    logic                 valid_i;
    logic                 ready_o;

    modport master (
        output L_DATA_I,
        output R_DATA_I,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  L_DATA_I,
        input  R_DATA_I,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/i2s_encoder_sample_buf.sv
// One-entry holding register for an L/R pair between the producer and the frame loader.
// Latency: pushed pair visible on l_o/r_o the cycle after push_i.
// Backpressure: full_o stays high from push until pop; the caller must not push while full.
// Ports: clk_mic/rst_mic_n, push_i (store pair), pop_i (frame loader took pair),
//        l_i/r_i (incoming pair), full_o (entry held), l_o/r_o (held pair).
module i2s_encoder_sample_buf
    import i2s_encoder_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk_mic,
    input  logic                 rst_mic_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DATAWIDTH-1:0] l_i,
    input  logic [DATAWIDTH-1:0] r_i,
    output logic                 full_o,
    output logic [DATAWIDTH-1:0] l_o,
    output logic [DATAWIDTH-1:0] r_o
);
    logic                 full_q, full_d;
    logic [DATAWIDTH-1:0] l_q, l_d;
    logic [DATAWIDTH-1:0] r_q, r_d;

    // A pop on an empty entry together with a push leaves the new pair stored:
    // the loader saw nothing, so the pair must survive for the next frame.
    always_comb begin
        full_d = full_q;
        l_d    = l_q;
        r_d    = r_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            full_d = 1'b1;
            l_d    = l_i;
            r_d    = r_i;
        end
    end

    always_ff @(negedge clk_mic or negedge rst_mic_n) begin
        if (!rst_mic_n) begin
            full_q <= 1'b0;
            l_q    <= '0;
            r_q    <= '0;
        end else begin
            full_q <= full_d;
            l_q    <= l_d;
            r_q    <= r_d;
        end
    end

    assign full_o = full_q;
    assign l_o    = l_q;
    assign r_o    = r_q;
endmodule

// File: rtl/i2s_encoder.sv
// Philips-I2S transmitter: serialises buffered L/R pairs, MSB one bit clock after each WS edge.
// Latency: a pair accepted into the empty buffer starts on DATA_O at the next frame boundary.
// Backpressure: smp.ready_o low while one pair is buffered; an empty buffer at a boundary sends zeros.
// Ports: clk_mic (SCK, all flops on its falling edge), rst_mic_n (async, active low),
//        en_i (run enable, sampled at frame boundary), smp (sample handshake, slave),
//        WS_O/DATA_O (serial line), frame_start_o (slot-0 pulse), underrun_o (empty-load pulse).
module i2s_encoder
    import i2s_encoder_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic         clk_mic,
    input  logic         rst_mic_n,
    input  logic         en_i,
    i2s_encoder_if.slave smp,
    output logic         WS_O,
    output logic         DATA_O,
    output logic         frame_start_o,
    output logic         underrun_o
);
    localparam int              FRAME_BITS = 2 * SLOT_BITS;
    localparam int              CW         = $clog2(FRAME_BITS);
    localparam logic [CW-1:0]   LAST_SLOT  = CW'(FRAME_BITS - 1);

    logic                 buf_full;
    logic [DATAWIDTH-1:0] buf_l, buf_r;
    logic                 push, load, at_boundary;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_nx;
    logic [DATAWIDTH-1:0] l_sr_q, r_sr_q;
    logic                 ws_q, data_q, fs_q, ur_q;

    assign smp.ready_o = ~buf_full;
    assign push        = smp.valid_i & ~buf_full;

    // IDLE always parks the counter on the last slot, so both conditions mark the boundary.
    assign at_boundary = (state_q == ST_IDLE) || (cnt_q == LAST_SLOT);
    assign load        = at_boundary & en_i;
    assign cnt_nx      = cnt_q + 1'b1;

    i2s_encoder_sample_buf #(
        .DATAWIDTH (DATAWIDTH)
    ) u_buf (
        .clk_mic   (clk_mic),
        .rst_mic_n (rst_mic_n),
        .push_i    (push),
        .pop_i     (load),
        .l_i       (smp.L_DATA_I),
        .r_i       (smp.R_DATA_I),
        .full_o    (buf_full),
        .l_o       (buf_l),
        .r_o       (buf_r)
    );

    // Every output register holds the value for the slot now in cnt_q, so each
    // branch computes the line state for the slot being entered.
    always_ff @(negedge clk_mic or negedge rst_mic_n) begin
        if (!rst_mic_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= LAST_SLOT;
            l_sr_q  <= '0;
            r_sr_q  <= '0;
            ws_q    <= WS_LEFT;
            data_q  <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            ur_q <= 1'b0;
            if (at_boundary) begin
                ws_q <= WS_LEFT;
                if (load) begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                    fs_q    <= 1'b1;
                    ur_q    <= ~buf_full;
                    // The left MSB goes straight to the line; the rest waits in the shifter.
                    if (buf_full) begin
                        data_q <= buf_l[DATAWIDTH-1];
                        l_sr_q <= {buf_l[DATAWIDTH-2:0], 1'b0};
                        r_sr_q <= buf_r;
                    end else begin
                        data_q <= 1'b0;
                        l_sr_q <= '0;
                        r_sr_q <= '0;
                    end
                end else begin
                    state_q <= ST_IDLE;
                    data_q  <= 1'b0;
                end
            end else begin
                cnt_q <= cnt_nx;
                ws_q  <= ws_for_slot(int'(cnt_nx), SLOT_BITS);
                if (int'(cnt_nx) < DATAWIDTH) begin
                    data_q <= l_sr_q[DATAWIDTH-1];
                    l_sr_q <= {l_sr_q[DATAWIDTH-2:0], 1'b0};
                end else if (int'(cnt_nx) >= SLOT_BITS && int'(cnt_nx) < SLOT_BITS + DATAWIDTH) begin
                    data_q <= r_sr_q[DATAWIDTH-1];
                    r_sr_q <= {r_sr_q[DATAWIDTH-2:0], 1'b0};
                end else begin
                    data_q <= 1'b0;
                end
            end
        end
    end

    assign WS_O          = ws_q;
    assign DATA_O        = data_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = ur_q;
endmodule

// File: tb/tb_i2s_encoder.sv
// Self-checking bench for i2s_encoder: slot-map reference model plus an I2S receiver.
// Latency n/a (bench).
// Backpressure: producer side waits on ready_o with bounded cycle budgets.
module tb_i2s_encoder;
    localparam int DW = 24;
    localparam int SB = 32;
    localparam int FB = 2 * SB;

    logic clk_mic   = 1'b0;
    logic rst_mic_n = 1'b0;
    logic en_i      = 1'b0;
    logic ws, dat, fs, ur;

    i2s_encoder_if #(.DATAWIDTH(DW)) smp_if ();

    i2s_encoder #(
        .DATAWIDTH (DW),
        .SLOT_BITS (SB)
    ) dut (
        .clk_mic       (clk_mic),
        .rst_mic_n     (rst_mic_n),
        .en_i          (en_i),
        .smp           (smp_if),
        .WS_O          (ws),
        .DATA_O        (dat),
        .frame_start_o (fs),
        .underrun_o    (ur)
    );

    always #5 clk_mic = ~clk_mic;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model (updated on the falling edge) ----------------
    int              m_slot = FB - 1;
    bit              m_full = 0;
    bit              m_fs   = 0;
    bit              m_ur   = 0;
    logic [DW-1:0]   m_bl = '0, m_br = '0, m_fl = '0, m_fr = '0;

    always @(negedge clk_mic) begin
        if (!rst_mic_n) begin
            m_slot = FB - 1;
            m_full = 0;
            m_fs   = 0;
            m_ur   = 0;
            m_fl   = '0;
            m_fr   = '0;
        end else begin
            bit acc;
            acc  = smp_if.valid_i && !m_full;
            m_fs = 0;
            m_ur = 0;
            if (m_slot == FB - 1) begin
                if (en_i) begin
                    m_slot = 0;
                    m_fs   = 1;
                    if (m_full) begin
                        m_fl   = m_bl;
                        m_fr   = m_br;
                        m_full = 0;
                    end else begin
                        m_fl = '0;
                        m_fr = '0;
                        m_ur = 1;
                    end
                end
            end else begin
                m_slot++;
            end
            if (acc) begin
                m_full = 1;
                m_bl   = smp_if.L_DATA_I;
                m_br   = smp_if.R_DATA_I;
            end
        end
    end

    // ---------------- per-cycle compare (rising edge, mid-bit) ----------------
    bit chk_on = 0;
    always @(posedge clk_mic) begin
        if (chk_on && rst_mic_n) begin
            logic ws_e, d_e;
            ws_e = (m_slot >= SB - 1 && m_slot <= FB - 2);
            if (m_slot < DW)                          d_e = m_fl[DW-1-m_slot];
            else if (m_slot >= SB && m_slot < SB + DW) d_e = m_fr[SB+DW-1-m_slot];
            else                                      d_e = 1'b0;
            chk("model_ws",    ws, ws_e);
            chk("model_data",  dat, d_e);
            chk("model_fs",    fs, m_fs);
            chk("model_ur",    ur, m_ur);
            chk("model_ready", smp_if.ready_o, !m_full);
        end
    end

    // ---------------- I2S receiver ----------------
    logic              rx_prev_ws;
    int                rx_idx = 99;
    logic [DW-1:0]     rx_w = '0, rx_l = '0;
    logic [2*DW-1:0]   rx_q[$];
    int                ur_cnt = 0;

    always @(posedge clk_mic) begin
        if (ur === 1'b1) ur_cnt++;
        if (rx_idx < DW) begin
            rx_w = {rx_w[DW-2:0], dat};
            if (rx_idx == DW - 1) begin
                if (ws == 1'b0) rx_l = rx_w;
                else            rx_q.push_back({rx_l, rx_w});
            end
        end
        if (ws !== rx_prev_ws) rx_idx = 0;
        else if (rx_idx < DW)  rx_idx++;
        rx_prev_ws = ws;
    end

    // ---------------- helpers ----------------
    task automatic wait_fs(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk_mic);
            if (fs === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4 * FB; i++) begin
            @(posedge clk_mic);
            if (smp_if.ready_o === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk("push_ready_seen", ok, 1);
        if (ok) begin
            #1;
            smp_if.L_DATA_I = l;
            smp_if.R_DATA_I = r;
            smp_if.valid_i  = 1'b1;
            @(posedge clk_mic);
            chk("ready_falls_on_accept", smp_if.ready_o, 0);
            #1;
            smp_if.valid_i  = 1'b0;
            smp_if.L_DATA_I = DW'($urandom);
            smp_if.R_DATA_I = DW'($urandom);
        end
    endtask

    logic [DW-1:0] pl[8], pr[8];

    initial begin
        bit          ok;
        logic [63:0] cap_d, cap_w;
        int          n_act, n_ws, n_fs, ur0, n;

        smp_if.valid_i  = 1'b0;
        smp_if.L_DATA_I = '0;
        smp_if.R_DATA_I = '0;

        // 1: reset values, then idle with en_i low
        repeat (3) @(posedge clk_mic);
        chk("rst_ws", ws, 0);
        chk("rst_data", dat, 0);
        chk("rst_fs", fs, 0);
        chk("rst_ur", ur, 0);
        chk("rst_ready", smp_if.ready_o, 1);
        #1 rst_mic_n = 1'b1;
        chk_on = 1;
        n_act = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_mic);
            if (ws !== 1'b0 || dat !== 1'b0 || fs !== 1'b0 || ur !== 1'b0 || smp_if.ready_o !== 1'b1) n_act++;
        end
        chk("idle_quiet_cycles", n_act, 0);

        // 2: preloaded pair, known bit pattern
        push_pair(24'h800001, 24'h7FFFFE);
        en_i = 1'b1;
        wait_fs(8, ok);
        chk("t2_fs_seen", ok, 1);
        chk("t2_no_underrun", ur, 0);
        chk("t2_ready_after_load", smp_if.ready_o, 1);
        cap_d = '0;
        cap_w = '0;
        for (int s = 0; s < FB; s++) begin
            if (s > 0) @(posedge clk_mic);
            cap_d[FB-1-s] = dat;
            cap_w[FB-1-s] = ws;
        end
        chk("t2_data_frame", cap_d, 64'h80000100_7FFFFE00);
        chk("t2_ws_frame",   cap_w, 64'h00000001_FFFFFFFE);

        // 3: running with nothing pending
        wait_fs(FB + 2, ok);
        chk("t3_fs_seen", ok, 1);
        chk("t3_underrun_at_slot0", ur, 1);
        cap_d = '0;
        n_act = 0;
        for (int s = 0; s < FB; s++) begin
            if (s > 0) @(posedge clk_mic);
            cap_d[FB-1-s] = dat;
            if (ur === 1'b1) n_act++;
        end
        chk("t3_data_zero", cap_d, 64'h0);
        chk("t3_one_ur_pulse", n_act, 1);

        // 4: stream 8 pairs, receiver decode
        for (int k = 0; k < 8; k++) begin
            pl[k] = DW'($urandom);
            pr[k] = DW'($urandom);
        end
        wait_fs(FB + 2, ok);
        chk("t4_fs_seen", ok, 1);
        rx_q.delete();
        push_pair(pl[0], pr[0]);
        ur0 = ur_cnt;
        for (int k = 1; k < 8; k++) push_pair(pl[k], pr[k]);
        wait_fs(FB + 2, ok);
        chk("t4_last_fs_seen", ok, 1);
        repeat (60) @(posedge clk_mic);
        chk("t4_no_underrun", ur_cnt - ur0, 0);
        chk("t4_rx_count", rx_q.size(), 9);
        if (rx_q.size() == 9) begin
            chk("t4_rx_lead_zero", rx_q[0], 0);
            for (int k = 0; k < 8; k++) chk("t4_rx_pair", rx_q[k+1], {pl[k], pr[k]});
        end

        // 5: drop enable mid-frame
        wait_fs(FB + 2, ok);
        chk("t5_fs_seen", ok, 1);
        repeat (10) @(posedge clk_mic);
        #1 en_i = 1'b0;
        n_ws = 0;
        n_fs = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_mic);
            if (ws === 1'b1) n_ws++;
            if (fs === 1'b1) n_fs++;
        end
        chk("t5_frame_completes_ws", n_ws, 32);
        chk("t5_no_restart", n_fs, 0);
        chk("t5_idle_ws", ws, 0);

        // 6: reset mid-frame with a pair buffered
        #1 en_i = 1'b1;
        wait_fs(8, ok);
        chk("t6_fs_seen", ok, 1);
        push_pair(24'h123456, 24'hABCDEF);
        repeat (38) @(posedge clk_mic);
        chk("t6_ws_before_reset", ws, 1);
        #1 rst_mic_n = 1'b0;
        #1;
        chk("t6_ws_reset", ws, 0);
        chk("t6_data_reset", dat, 0);
        chk("t6_ready_reset", smp_if.ready_o, 1);
        repeat (3) @(posedge clk_mic);
        #1 rst_mic_n = 1'b1;
        n = 0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_mic);
            n++;
            if (fs === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk("t6_restart_fs", ok, 1);
        chk("t6_restart_cycles", n, 1);
        chk("t6_pair_lost_underrun", ur, 1);

        // random traffic with random enable toggling
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_mic);
            #1;
            if ($urandom_range(0, 39) == 0) en_i = ~en_i;
            smp_if.valid_i  = ($urandom_range(0, 3) == 0);
            smp_if.L_DATA_I = DW'($urandom);
            smp_if.R_DATA_I = DW'($urandom);
        end
        en_i           = 1'b0;
        smp_if.valid_i = 1'b0;
        repeat (150) @(posedge clk_mic);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
